// File: rtl/m_muldiv_pkg.sv
// Shared types and op-decode helpers for the RISC-V M-extension multiply/divide unit.
// No logic state; latency and backpressure are defined by m_muldiv_unit.
package m_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } m_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic is_signed_a(m_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(m_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(m_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(m_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // Iteration counter width for an XLEN-bit divide.
  function automatic int div_cnt_w(int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/m_muldiv_mul_pipe.sv
// Signed WxW multiplier with STAGES output registers, product truncated to PW bits.
// Latency STAGES cycles while i_en is high; i_en low freezes every stage (holds the result).
module m_mul_pipe #(
  parameter int W      = 33,
  parameter int PW     = 64,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  output logic [PW-1:0] o_p
);

  logic [PW-1:0] w_a_x;
  logic [PW-1:0] w_b_x;
  logic [PW-1:0] r_pipe [STAGES];

  // Sign-extending to PW first makes the truncated unsigned product equal the signed one.
  assign w_a_x = {{(PW-W){i_a[W-1]}}, i_a};
  assign w_b_x = {{(PW-W){i_b[W-1]}}, i_b};

  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
    end else if (i_en) begin
      r_pipe[0] <= w_a_x * w_b_x;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_p = r_pipe[STAGES-1];

endmodule

// File: rtl/m_muldiv_unit.sv
// RISC-V M-extension mul/div unit: MUL* MUL_STAGES+1, DIV* XLEN+2, div-by-zero/overflow 1 cycle.
// One request in flight; in_ready only in IDLE, result held stable until out_ready.
module m_muldiv_unit
  import m_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  m_op_e            in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = div_cnt_w(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state, w_next;
  m_op_e             r_op;
  logic [TAG_W-1:0]  r_tag;
  logic              r_a_neg, r_b_neg;
  logic [XLEN-1:0]   r_r, r_z, r_res;
  logic [2*XLEN-2:0] r_d;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept, w_div0, w_ovf, w_ge, w_pipe_en;
  logic [XLEN:0]     w_a_ext, w_b_ext;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_special, w_mul_res, w_q_fix, w_r_fix;
  logic [2*XLEN-1:0] w_prod;

  assign in_ready   = (r_state == ST_IDLE) && !reset;
  assign w_accept   = in_valid && in_ready && !flush;
  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_res;
  assign out_tag    = r_tag;

  assign w_a_ext   = {is_signed_a(in_op) & in_rs1[XLEN-1], in_rs1};
  assign w_b_ext   = {is_signed_b(in_op) & in_rs2[XLEN-1], in_rs2};
  assign w_abs_a   = (is_signed_a(in_op) && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
  assign w_abs_b   = (is_signed_b(in_op) && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;
  assign w_div0    = (in_rs2 == '0);
  assign w_ovf     = is_signed_a(in_op) && (in_rs1 == MOST_NEG) && (in_rs2 == '1);
  assign w_special = w_div0 ? (is_rem(in_op) ? in_rs1 : '1)
                            : (is_rem(in_op) ? '0 : in_rs1);

  // Multiplier takes operands straight from the request so the product lands on time.
  assign w_pipe_en = w_accept || (r_state == ST_MUL);

  m_mul_pipe #(
    .W      (XLEN + 1),
    .PW     (2 * XLEN),
    .STAGES (MUL_STAGES)
  ) u_mul_pipe (
    .clk     (clk),
    .i_reset (reset),
    .i_en    (w_pipe_en),
    .i_a     (w_a_ext),
    .i_b     (w_b_ext),
    .o_p     (w_prod)
  );

  assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_ge      = ({{(XLEN-1){1'b0}}, r_r} >= r_d);
  assign w_q_fix   = (is_signed_a(r_op) && (r_a_neg ^ r_b_neg)) ? -r_z : r_z;
  assign w_r_fix   = (is_signed_a(r_op) && r_a_neg) ? -r_r : r_r;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (!is_div(in_op))      w_next = ST_MUL;
        else if (w_div0 || w_ovf) w_next = ST_DONE;
        else                     w_next = ST_DIV;
      end
      ST_MUL:  if (r_cnt == CNT_W'(MUL_STAGES - 1)) w_next = ST_DONE;
      ST_DIV:  if (r_cnt == CNT_W'(XLEN - 1)) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MUL;
      r_tag   <= '0;
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
      r_r     <= '0;
      r_d     <= '0;
      r_z     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= in_op;
          r_tag   <= in_tag;
          r_a_neg <= in_rs1[XLEN-1];
          r_b_neg <= in_rs2[XLEN-1];
          r_r     <= w_abs_a;
          r_d     <= {w_abs_b, {(XLEN-1){1'b0}}};
          r_z     <= '0;
          r_cnt   <= '0;
          if (w_next == ST_DONE) r_res <= w_special;
        end
        ST_MUL: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_next == ST_DONE) r_res <= w_mul_res;
        end
        ST_DIV: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_ge) r_r <= r_r - r_d[XLEN-1:0];
          r_z <= {r_z[XLEN-2:0], w_ge};
          r_d <= r_d >> 1;
        end
        ST_FIX: if (w_next == ST_DONE) r_res <= is_rem(r_op) ? w_r_fix : w_q_fix;
        default: ;
      endcase
    end
  end

  a_op_known: assert property (@(posedge clk) disable iff (reset)
    (in_valid && in_ready) |-> !$isunknown(in_op));

endmodule
